// File: rtl/spi_slave_regif.sv
// SPI mode-0 target that turns 16-bit master frames into register-file read/write strobes.
// Optional feature: define SPI_SLAVE_STATUS_EN to shift the status byte out during the command byte.
module spi_slave_regif #(
   parameter int unsigned ADDR_W      = 7,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              osc_clk,
   input  logic              rst,
   input  logic              spi_clk,
   input  logic              spi_cs_INV,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   output logic              wr_stb,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              rd_stb,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   input  logic [DATA_W-1:0] status,
   output logic              frame_err
);
   localparam int unsigned CMD_W   = 1 + ADDR_W;
   localparam int unsigned FRAME_W = CMD_W + DATA_W;
   localparam int unsigned RX_W    = (CMD_W > DATA_W) ? CMD_W : DATA_W;
   localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
   localparam int unsigned SYNC_N  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA, ST_DONE} state_e;

   state_e              state_q, state_d;
   logic [SYNC_N-1:0]   sclk_sync_q, sclk_sync_d;
   logic [SYNC_N-1:0]   cs_sync_q, cs_sync_d;
   logic [SYNC_N-1:0]   mosi_sync_q, mosi_sync_d;
   logic                sclk_prev_q, sclk_prev_d;
   logic                cs_prev_q, cs_prev_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [RX_W-1:0]     rx_q, rx_d;
   logic [DATA_W-1:0]   tx_q, tx_d;
   logic                is_rd_q, is_rd_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [1:0]          rd_dly_q, rd_dly_d;
   logic                err_seen_q, err_seen_d;
   logic                spi_miso_q, spi_miso_d;
   logic                spi_miso_oe_q, spi_miso_oe_d;
   logic                wr_stb_q, wr_stb_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic                rd_stb_q, rd_stb_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic                frame_err_q, frame_err_d;

   logic sclk_s, cs_s, mosi_s;
   logic sclk_rise, sclk_fall, cs_fall, cs_rise;

   assign sclk_s    = sclk_sync_q[SYNC_N-1];
   assign cs_s      = cs_sync_q[SYNC_N-1];
   assign mosi_s    = mosi_sync_q[SYNC_N-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q & ~cs_s;
   assign sclk_fall = ~sclk_s & sclk_prev_q & ~cs_s;
   assign cs_fall   = ~cs_s & cs_prev_q;
   assign cs_rise   = cs_s & ~cs_prev_q;

`ifndef SPI_SLAVE_STATUS_EN
   logic unused_status;
   assign unused_status = ^status;
`endif

   // Frame decoder: next-state and registered-output logic
   always_comb begin
      sclk_sync_d   = {sclk_sync_q[SYNC_N-2:0], spi_clk};
      cs_sync_d     = {cs_sync_q[SYNC_N-2:0], spi_cs_INV};
      mosi_sync_d   = {mosi_sync_q[SYNC_N-2:0], spi_mosi};
      sclk_prev_d   = sclk_s;
      cs_prev_d     = cs_s;
      state_d       = state_q;
      cnt_d         = cnt_q;
      rx_d          = rx_q;
      tx_d          = tx_q;
      is_rd_d       = is_rd_q;
      addr_d        = addr_q;
      rd_dly_d      = {rd_dly_q[0], rd_stb_q};
      err_seen_d    = err_seen_q;
      spi_miso_d    = spi_miso_q;
      spi_miso_oe_d = spi_miso_oe_q;
      wr_stb_d      = 1'b0;
      wr_addr_d     = wr_addr_q;
      wr_data_d     = wr_data_q;
      rd_stb_d      = 1'b0;
      rd_addr_d     = rd_addr_q;
      frame_err_d   = 1'b0;

      // Register file answers two cycles after the read strobe
      if (rd_dly_q[1]) tx_d = rd_data;

      case (state_q)
         ST_IDLE: begin
            spi_miso_oe_d = 1'b0;
            spi_miso_d    = 1'b0;
            if (cs_fall) begin
               state_d       = ST_CMD;
               cnt_d         = '0;
               rx_d          = '0;
               err_seen_d    = 1'b0;
               spi_miso_oe_d = 1'b1;
`ifdef SPI_SLAVE_STATUS_EN
               spi_miso_d    = status[DATA_W-1];
               tx_d          = status << 1;
`endif
            end
         end
         ST_CMD: begin
            if (cs_rise) begin
               state_d       = ST_IDLE;
               frame_err_d   = 1'b1;
               spi_miso_oe_d = 1'b0;
               spi_miso_d    = 1'b0;
            end else if (sclk_rise) begin
               rx_d  = {rx_q[RX_W-2:0], mosi_s};
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_d == CNT_W'(CMD_W)) begin
                  is_rd_d = rx_d[CMD_W-1];
                  addr_d  = rx_d[ADDR_W-1:0];
                  state_d = ST_DATA;
                  if (rx_d[CMD_W-1]) begin
                     rd_stb_d  = 1'b1;
                     rd_addr_d = rx_d[ADDR_W-1:0];
                  end else begin
                     spi_miso_d = 1'b0;
                  end
               end
`ifdef SPI_SLAVE_STATUS_EN
            end else if (sclk_fall) begin
               spi_miso_d = tx_q[DATA_W-1];
               tx_d       = tx_q << 1;
`endif
            end
         end
         ST_DATA: begin
            if (cs_rise) begin
               state_d       = ST_IDLE;
               frame_err_d   = 1'b1;
               spi_miso_oe_d = 1'b0;
               spi_miso_d    = 1'b0;
            end else if (sclk_rise) begin
               rx_d  = {rx_q[RX_W-2:0], mosi_s};
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_d == CNT_W'(FRAME_W)) begin
                  state_d    = ST_DONE;
                  spi_miso_d = 1'b0;
                  if (!is_rd_q) begin
                     wr_stb_d  = 1'b1;
                     wr_addr_d = addr_q;
                     wr_data_d = rx_d[DATA_W-1:0];
                  end
               end
            end else if (sclk_fall) begin
               if (is_rd_q) begin
                  spi_miso_d = tx_q[DATA_W-1];
                  tx_d       = tx_q << 1;
               end else begin
                  spi_miso_d = 1'b0;
               end
            end
         end
         ST_DONE: begin
            spi_miso_d = 1'b0;
            if (cs_rise) begin
               state_d       = ST_IDLE;
               spi_miso_oe_d = 1'b0;
            end else if (sclk_rise && !err_seen_q) begin
               frame_err_d = 1'b1;
               err_seen_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // CS chain resets to "asserted" so a CS held low across reset never looks like a fresh frame
   always_ff @(posedge osc_clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         sclk_sync_q   <= '0;
         cs_sync_q     <= '0;
         mosi_sync_q   <= '0;
         sclk_prev_q   <= 1'b0;
         cs_prev_q     <= 1'b0;
         cnt_q         <= '0;
         rx_q          <= '0;
         tx_q          <= '0;
         is_rd_q       <= 1'b0;
         addr_q        <= '0;
         rd_dly_q      <= '0;
         err_seen_q    <= 1'b0;
         spi_miso_q    <= 1'b0;
         spi_miso_oe_q <= 1'b0;
         wr_stb_q      <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         rd_stb_q      <= 1'b0;
         rd_addr_q     <= '0;
         frame_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         sclk_sync_q   <= sclk_sync_d;
         cs_sync_q     <= cs_sync_d;
         mosi_sync_q   <= mosi_sync_d;
         sclk_prev_q   <= sclk_prev_d;
         cs_prev_q     <= cs_prev_d;
         cnt_q         <= cnt_d;
         rx_q          <= rx_d;
         tx_q          <= tx_d;
         is_rd_q       <= is_rd_d;
         addr_q        <= addr_d;
         rd_dly_q      <= rd_dly_d;
         err_seen_q    <= err_seen_d;
         spi_miso_q    <= spi_miso_d;
         spi_miso_oe_q <= spi_miso_oe_d;
         wr_stb_q      <= wr_stb_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
         rd_stb_q      <= rd_stb_d;
         rd_addr_q     <= rd_addr_d;
         frame_err_q   <= frame_err_d;
      end
   end

   assign spi_miso    = spi_miso_q;
   assign spi_miso_oe = spi_miso_oe_q;
   assign wr_stb      = wr_stb_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign rd_stb      = rd_stb_q;
   assign rd_addr     = rd_addr_q;
   assign frame_err   = frame_err_q;

endmodule
